// File: rtl/sys_cmd_pkg.sv
// Shared constants for the host-side UART command initiator: opcodes, command
// types, FSM states and per-type frame shape.
package sys_cmd_pkg;

  localparam logic [7:0] OP_RF_WR   = 8'hAA;
  localparam logic [7:0] OP_RF_RD   = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CmdRfWr   = 2'd0,
    CmdRfRd   = 2'd1,
    CmdAluOp  = 2'd2,
    CmdAluNop = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSend     = 3'd1,
    StWaitAck  = 3'd2,
    StWaitFree = 3'd3,
    StWaitRsp  = 3'd4
  } state_e;

  function automatic logic [7:0] type_opcode(input cmd_type_e t);
    unique case (t)
      CmdRfWr:   return OP_RF_WR;
      CmdRfRd:   return OP_RF_RD;
      CmdAluOp:  return OP_ALU_OP;
      default:   return OP_ALU_NOP;
    endcase
  endfunction

  // Index of the final byte in the frame (frame length minus one).
  function automatic logic [1:0] frame_last(input cmd_type_e t);
    unique case (t)
      CmdRfWr:   return 2'd2;
      CmdRfRd:   return 2'd1;
      CmdAluOp:  return 2'd3;
      default:   return 2'd1;
    endcase
  endfunction

  function automatic logic rsp_expected(input cmd_type_e t);
    return (t != CmdRfWr);
  endfunction

endpackage

// File: rtl/sys_cmd_timer.sv
// Response timeout counter: clearable/loadable up-counter that flags when it
// sits on the terminal count.
module sys_cmd_timer #(
  parameter int unsigned TO_WIDTH = 16,
  parameter int unsigned TERMINAL = 49999
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic [TO_WIDTH-1:0] i_load_val,
  input  logic                i_inc,
  output logic                o_tc
);

  logic [TO_WIDTH-1:0] r_count;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc) begin
      r_count <= r_count + TO_WIDTH'(1);
    end
  end

  assign o_tc = (r_count == TO_WIDTH'(TERMINAL));

endmodule

// File: rtl/sys_cmd_host.sv
// Host command initiator: serialises one command into UART transmit bytes and
// collects the single response byte with a cycle timeout.
module sys_cmd_host
  import sys_cmd_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned ADDRESS_WIDTH  = 4,
  parameter int unsigned FUN_WIDTH      = 4,
  parameter int unsigned TO_WIDTH       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Cmd_Valid,
  output logic                     Cmd_Ready,
  input  logic [1:0]               Cmd_Type,
  input  logic [ADDRESS_WIDTH-1:0] Cmd_Addr,
  input  logic [WIDTH-1:0]         Cmd_A,
  input  logic [WIDTH-1:0]         Cmd_B,
  input  logic [FUN_WIDTH-1:0]     Cmd_Fun,
  output logic [WIDTH-1:0]         TX_P_DATA,
  output logic                     TX_D_VLD,
  input  logic                     Busy,
  input  logic [WIDTH-1:0]         RX_P_DATA,
  input  logic                     RX_D_VLD,
  output logic [WIDTH-1:0]         Rsp_Data,
  output logic                     Rsp_Valid,
  output logic                     Rsp_Timeout,
  output logic                     Done
);

  state_e                   r_state, w_state_d;
  cmd_type_e                r_type;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]         r_a, r_b;
  logic [FUN_WIDTH-1:0]     r_fun;
  logic [1:0]               r_idx, w_idx_d;
  logic [WIDTH-1:0]         r_tx_data, r_rsp_data;
  logic [WIDTH-1:0]         w_byte;
  logic                     w_accept, w_tx_vld, w_rsp_vld, w_rsp_to, w_done;
  logic                     w_tmr_clr, w_tmr_inc, w_tc;

  sys_cmd_timer #(
    .TO_WIDTH (TO_WIDTH),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_timer (
    .CLK        (CLK),
    .RST        (RST),
    .i_clr      (w_tmr_clr),
    .i_load     (1'b0),
    .i_load_val ({TO_WIDTH{1'b0}}),
    .i_inc      (w_tmr_inc),
    .o_tc       (w_tc)
  );

  always_comb begin
    w_byte = '0;
    if (r_idx == 2'd0) begin
      w_byte = WIDTH'(type_opcode(r_type));
    end else begin
      unique case (r_type)
        CmdRfWr:  w_byte = (r_idx == 2'd1) ? WIDTH'(r_addr) : r_a;
        CmdRfRd:  w_byte = WIDTH'(r_addr);
        CmdAluOp: w_byte = (r_idx == 2'd1) ? r_a :
                           (r_idx == 2'd2) ? r_b : WIDTH'(r_fun);
        default:  w_byte = WIDTH'(r_fun);
      endcase
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_accept  = 1'b0;
    w_tx_vld  = 1'b0;
    w_rsp_vld = 1'b0;
    w_rsp_to  = 1'b0;
    w_done    = 1'b0;
    w_tmr_clr = 1'b0;
    w_tmr_inc = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (Cmd_Valid) begin
          w_accept  = 1'b1;
          w_idx_d   = 2'd0;
          w_state_d = StSend;
        end
      end
      StSend: begin
        if (!Busy) begin
          w_tx_vld  = 1'b1;
          w_state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (Busy) w_state_d = StWaitFree;
      end
      StWaitFree: begin
        if (!Busy) begin
          if (r_idx != frame_last(r_type)) begin
            w_idx_d   = r_idx + 2'd1;
            w_state_d = StSend;
          end else if (rsp_expected(r_type)) begin
            w_tmr_clr = 1'b1;
            w_state_d = StWaitRsp;
          end else begin
            w_done    = 1'b1;
            w_state_d = StIdle;
          end
        end
      end
      StWaitRsp: begin
        // Data arriving on the terminal-count cycle takes priority over timeout.
        if (RX_D_VLD) begin
          w_rsp_vld = 1'b1;
          w_done    = 1'b1;
          w_state_d = StIdle;
        end else if (w_tc) begin
          w_rsp_to  = 1'b1;
          w_done    = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= StIdle;
      r_type     <= CmdRfWr;
      r_addr     <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_fun      <= '0;
      r_idx      <= '0;
      r_tx_data  <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      if (w_accept) begin
        r_type <= cmd_type_e'(Cmd_Type);
        r_addr <= Cmd_Addr;
        r_a    <= Cmd_A;
        r_b    <= Cmd_B;
        r_fun  <= Cmd_Fun;
      end
      if (w_tx_vld)  r_tx_data  <= w_byte;
      if (w_rsp_vld) r_rsp_data <= RX_P_DATA;
    end
  end

  // Byte and response data are visible in the same cycle as their strobes,
  // then held by the registers.
  assign TX_P_DATA   = w_tx_vld ? w_byte : r_tx_data;
  assign TX_D_VLD    = w_tx_vld;
  assign Rsp_Data    = w_rsp_vld ? RX_P_DATA : r_rsp_data;
  assign Rsp_Valid   = w_rsp_vld;
  assign Rsp_Timeout = w_rsp_to;
  assign Done        = w_done;
  assign Cmd_Ready   = (r_state == StIdle);

endmodule

// File: doc/sys_cmd_host.md
Name: sys_cmd_host

Overview:
- Host-side command initiator for the UART register/ALU command protocol served by the system controller.
- Accepts one command per handshake and serialises it into opcode and operand bytes toward a UART transmitter's parallel interface.
- Waits for the single response byte from a UART receiver's parallel interface, with a cycle timeout.
- Sits in the host domain or a loopback bench harness, directly on the parallel side of the UART pair.

Parameters:
WIDTH, 8, data/byte width
ADDRESS_WIDTH, 4, register file address width (zero-extended into the address byte)
FUN_WIDTH, 4, ALU function width (zero-extended into the function byte)
TO_WIDTH, 16, timeout counter width
TIMEOUT_CYCLES, 50000, cycles allowed in WAIT_RSP before timeout (must be ≥2 and < 2^TO_WIDTH)

Ports:
CLK  in  1  block clock; single clock domain
RST  in  1  asynchronous, active-low reset
Cmd_Valid  in  1  command request
Cmd_Ready  out  1  block idle, can accept a command
Cmd_Type  in  2  0=RF_WR, 1=RF_RD, 2=ALU_OP, 3=ALU_NOP
Cmd_Addr  in  ADDRESS_WIDTH  RF address
Cmd_A  in  WIDTH  write data (RF_WR) or operand A (ALU_OP)
Cmd_B  in  WIDTH  operand B (ALU_OP)
Cmd_Fun  in  FUN_WIDTH  ALU function
TX_P_DATA  out  WIDTH  byte to UART transmitter
TX_D_VLD  out  1  one-cycle byte-valid pulse
Busy  in  1  UART transmitter busy
RX_P_DATA  in  WIDTH  byte from UART receiver
RX_D_VLD  in  1  one-cycle received-byte pulse
Rsp_Data  out  WIDTH  last response byte
Rsp_Valid  out  1  one-cycle pulse: Rsp_Data updated
Rsp_Timeout  out  1  one-cycle pulse: no response in time
Done  out  1  one-cycle pulse: command finished (any outcome)

Behaviour:
- Reset values:
  - State IDLE; Cmd_Ready=1.
  - TX_P_DATA, Rsp_Data, timer, byte index all 0.
  - TX_D_VLD, Rsp_Valid, Rsp_Timeout, Done all 0.
  - Reset mid-command aborts the command immediately with no Done.
- Frames, sent in order:
  - RF_WR: 0xAA, addr, A. No response.
  - RF_RD: 0xBB, addr. One response byte.
  - ALU_OP: 0xCC, A, B, fun. One response byte.
  - ALU_NOP: 0xDD, fun. One response byte.
  - Address and function bytes are zero-extended to WIDTH.
- Accept: when Cmd_Valid && Cmd_Ready, latch all Cmd_* fields and go to SEND. Cmd_Ready is 0 in every other state. Inputs are ignored while not ready.
- FSM states: IDLE, SEND, WAIT_ACK, WAIT_FREE, WAIT_RSP.
  - SEND: if Busy=0, drive TX_P_DATA=current byte and TX_D_VLD=1 for exactly one cycle, then go to WAIT_ACK. If Busy=1, stay in SEND.
  - WAIT_ACK: wait for Busy=1, then go to WAIT_FREE.
  - WAIT_FREE: wait for Busy=0. If more bytes remain, increment the index and return to SEND. If the frame is complete: RF_WR goes to IDLE with Done pulse; all other types clear the timer and go to WAIT_RSP.
  - WAIT_RSP: on RX_D_VLD, set Rsp_Data=RX_P_DATA, pulse Rsp_Valid and Done in the same cycle, go to IDLE. Otherwise increment the timer. When timer == TIMEOUT_CYCLES-1 with no RX_D_VLD, pulse Rsp_Timeout and Done, go to IDLE; Rsp_Data is unchanged.
- Simultaneous RX_D_VLD and timeout terminal count: the data wins, no timeout pulse.
- RX_D_VLD in any state other than WAIT_RSP is ignored. A second response byte is never captured.
- TX_P_DATA holds its last byte between pulses.
- Latency:
  - With Busy idle, the first TX_D_VLD occurs 1 cycle after accept.
  - Rsp_Valid and Done occur in the same cycle as RX_D_VLD is sampled.
  - Cmd_Ready returns the following cycle.
- Back-to-back commands: the earliest accept of a new command is the cycle after Done.

Decomposition:
- Package sys_cmd_pkg holds:
  - Opcode constants (0xAA, 0xBB, 0xCC, 0xDD).
  - Cmd_Type encodings.
  - FSM state encoding.
  - Per-type frame length (3/2/4/2) and response-expected flag.
- Sub-module sys_cmd_timer: loadable/clearable TO_WIDTH up-counter with terminal-count output, used for WAIT_RSP.
- Byte selection stays inline as a mux on the latched type and index.

Test Plan:
1. RF_WR addr=4, A=0x5A, Busy model high 10 cycles per byte -> TX bytes 0xAA,0x04,0x5A each pulsed once; Done 1 cycle after final Busy fall; no Rsp_Valid.
2. RF_RD addr=2, responder returns 0x81 after 20 cycles -> TX 0xBB,0x02; Rsp_Data=0x81 with Rsp_Valid=Done=1 same cycle; Cmd_Ready=1 next cycle.
3. ALU_OP A=0x0C, B=0x03, fun=0 -> TX 0xCC,0x0C,0x03,0x00; response 0x0F captured.
4. ALU_NOP fun=2 with no response, TIMEOUT_CYCLES=100 -> Rsp_Timeout and Done exactly 100 cycles after WAIT_RSP entry; Rsp_Data keeps the prior 0x0F.
5. RX_D_VLD on the terminal-count cycle -> Rsp_Valid=1, Rsp_Timeout=0. Stray RX_D_VLD=0x77 in IDLE -> Rsp_Data unchanged.
6. Busy held high at accept, then RST low during WAIT_FREE of byte 2 -> no TX_D_VLD while Busy=1; after reset TX_D_VLD=0, Cmd_Ready=1, no Done.
